// File: rtl/uart_rx_if.sv
// Byte-side handshake and status signals of the UART receiver, plus the serial line.
// master = receiver, slave = consumer / line driver.
interface uart_rx_if;
  logic       rx_i;
  logic [7:0] data_o;
  logic       data_vld_o;
  logic       data_rdy_i;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (
    input  rx_i,
    input  data_rdy_i,
    output data_o,
    output data_vld_o,
    output frame_err_o,
    output overrun_o
  );

  modport slave (
    output rx_i,
    output data_rdy_i,
    input  data_o,
    input  data_vld_o,
    input  frame_err_o,
    input  overrun_o
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised rx line, byte output with
// valid/ready handshake, one-cycle framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic     clk_i,
  input  logic     rst_i,
  uart_rx_if.master rx_bus
);

  if (BAUD_DIV < 4) begin : g_baud_check
    $error("uart_rx: BAUD_DIV must be >= 4");
  end

  localparam int unsigned CW   = $clog2(BAUD_DIV);
  localparam int unsigned HALF = BAUD_DIV / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic [7:0]    data_q;
  logic          vld_q;
  logic          ferr_q;
  logic          ovr_q;
  logic          rx_m;
  logic          rx_s;
  logic          fire;
  logic          sample;
  logic          load;
  logic          ovr;
  logic          ferr;

  always_comb begin
    fire = 1'b0;
    case (state)
      S_START:        fire = (cnt == CW'(HALF - 1));
      S_DATA, S_STOP: fire = (cnt == CW'(BAUD_DIV - 1));
      default:        fire = 1'b0;
    endcase
  end

  // State register; the bit counter restarts on every state entry and every bit fire.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || fire || state == S_IDLE || state == S_BREAK)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!rx_s) state_nx = S_START;
      S_START: if (fire) state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (fire && idx == 3'd7) state_nx = S_STOP;
      S_STOP:  if (fire) state_nx = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // A consume in the same cycle as the stop sample frees the slot, so no overrun.
  always_comb begin
    sample = (state == S_DATA) && fire;
    load   = (state == S_STOP) && fire && rx_s && (!vld_q || rx_bus.data_rdy_i);
    ovr    = (state == S_STOP) && fire && rx_s && vld_q && !rx_bus.data_rdy_i;
    ferr   = (state == S_STOP) && fire && !rx_s;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      idx    <= '0;
      shreg  <= '0;
      data_q <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      rx_m   <= rx_bus.rx_i;
      rx_s   <= rx_m;
      ferr_q <= ferr;
      ovr_q  <= ovr;
      if (state == S_START && fire)
        idx <= '0;
      else if (sample)
        idx <= idx + 3'd1;
      if (sample)
        shreg[idx] <= rx_s;
      if (load) begin
        data_q <= shreg;
        vld_q  <= 1'b1;
      end else if (vld_q && rx_bus.data_rdy_i) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign rx_bus.data_o      = data_q;
  assign rx_bus.data_vld_o  = vld_q;
  assign rx_bus.frame_err_o = ferr_q;
  assign rx_bus.overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (BAUD_DIV=8): stimulus pushes expected bytes into a
// scoreboard queue, a negedge monitor pops and compares on each valid rise.
module tb_uart_rx;
  localparam int unsigned BD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if rx_bus ();

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .rx_bus (rx_bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  int unsigned cyc    = 0;
  logic [7:0]  exp_q[$];
  int          ferr_cnt = 0;
  int          ovr_cnt  = 0;
  int unsigned vld_rise_cyc = 0;
  int unsigned ovr_cyc      = 0;
  int unsigned t_start      = 0;
  bit          auto_rdy  = 1'b0;
  bit          force_rdy = 1'b0;
  int          rdy_dly   = 2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor and pulse-shape checks.
  initial begin
    logic       vld_prev;
    logic       ferr_prev;
    logic       ovr_prev;
    logic [7:0] held;
    vld_prev = 1'b0; ferr_prev = 1'b0; ovr_prev = 1'b0; held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        vld_prev = 1'b0; ferr_prev = 1'b0; ovr_prev = 1'b0;
      end else begin
        if (rx_bus.data_vld_o && !vld_prev) begin
          vld_rise_cyc = cyc;
          held = rx_bus.data_o;
          if (exp_q.size() == 0)
            check("unexpected_byte", 32'(exp_q.size()), 32'd1);
          else
            check("byte_data", 32'(rx_bus.data_o), 32'(exp_q.pop_front()));
        end else if (rx_bus.data_vld_o && vld_prev) begin
          check("data_stable", 32'(rx_bus.data_o), 32'(held));
        end
        if (rx_bus.frame_err_o || rx_bus.overrun_o)
          check("err_exclusive", 32'(rx_bus.frame_err_o && rx_bus.overrun_o), 32'd0);
        if (rx_bus.frame_err_o) begin
          ferr_cnt++;
          check("ferr_one_cycle", 32'(ferr_prev), 32'd0);
        end
        if (rx_bus.overrun_o) begin
          ovr_cnt++;
          ovr_cyc = cyc;
          check("ovr_one_cycle", 32'(ovr_prev), 32'd0);
        end
        vld_prev  = rx_bus.data_vld_o;
        ferr_prev = rx_bus.frame_err_o;
        ovr_prev  = rx_bus.overrun_o;
      end
    end
  end

  // Consumer: manual ready, or automatic ready rdy_dly cycles after valid, held until valid drops.
  initial begin
    int wcnt;
    wcnt = 0;
    rx_bus.data_rdy_i = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!auto_rdy) begin
        rx_bus.data_rdy_i = force_rdy;
        wcnt = 0;
      end else if (rx_bus.data_vld_o && !rx_bus.data_rdy_i) begin
        wcnt++;
        if (wcnt >= rdy_dly) rx_bus.data_rdy_i = 1'b1;
      end else if (!rx_bus.data_vld_o) begin
        rx_bus.data_rdy_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_bus.rx_i = 1'b0;
    t_start = cyc;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_bus.rx_i = b[i];
      repeat (BD) @(negedge clk);
    end
    rx_bus.rx_i = stop;
    repeat (BD) @(negedge clk);
  endtask

  task automatic wait_vld(input string name, input int limit);
    int n;
    n = 0;
    while (!rx_bus.data_vld_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(rx_bus.data_vld_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int o0;
    int unsigned lat;
    rx_bus.rx_i = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(rx_bus.data_o), 32'h00);
    check("rst_vld", 32'(rx_bus.data_vld_o), 32'd0);
    check("rst_ferr", 32'(rx_bus.frame_err_o), 32'd0);
    check("rst_ovr", 32'(rx_bus.overrun_o), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte, latency, hold, then consume
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    wait_vld("t1_vld", 20);
    lat = vld_rise_cyc - t_start;
    check("t1_latency_in_78_80", 32'(lat >= 78 && lat <= 80), 32'd1);
    repeat (50) @(negedge clk);
    check("t1_vld_held", 32'(rx_bus.data_vld_o), 32'd1);
    check("t1_data_held", 32'(rx_bus.data_o), 32'hA5);
    force_rdy = 1'b1;
    @(negedge clk);
    check("t1_vld_drop", 32'(rx_bus.data_vld_o), 32'd0);
    force_rdy = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back bytes with auto consumer
    f0 = ferr_cnt; o0 = ovr_cnt;
    auto_rdy = 1'b1;
    exp_q.push_back(8'h2E);
    exp_q.push_back(8'h55);
    send_byte(8'h2E, 1'b1);
    send_byte(8'h55, 1'b1);
    repeat (30) @(negedge clk);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t2_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t2_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    // Overrun
    auto_rdy = 1'b0; force_rdy = 1'b0;
    f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    check("t3_ovr_count", 32'(ovr_cnt - o0), 32'd1);
    lat = ovr_cyc - t_start;
    check("t3_ovr_at_stop_in_78_80", 32'(lat >= 78 && lat <= 80), 32'd1);
    check("t3_data_kept", 32'(rx_bus.data_o), 32'h11);
    check("t3_vld_kept", 32'(rx_bus.data_vld_o), 32'd1);
    check("t3_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    repeat (100) @(negedge clk);
    check("t3_vld_cleared", 32'(rx_bus.data_vld_o), 32'd0);
    check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Framing error followed by a long break
    auto_rdy = 1'b1;
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_byte(8'h3C, 1'b0);
    repeat (30 * BD) @(negedge clk);
    rx_bus.rx_i = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check("t4_ferr_count", 32'(ferr_cnt - f0), 32'd1);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    repeat (30) @(negedge clk);
    check("t4_ferr_total", 32'(ferr_cnt - f0), 32'd1);
    check("t4_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Start-bit glitch rejection
    f0 = ferr_cnt; o0 = ovr_cnt;
    rx_bus.rx_i = 1'b0;
    repeat (2) @(negedge clk);
    rx_bus.rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_vld", 32'(rx_bus.data_vld_o), 32'd0);
    check("t5_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t5_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    exp_q.push_back(8'h2A);
    send_byte(8'h2A, 1'b1);
    repeat (30) @(negedge clk);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with a byte pending
    auto_rdy = 1'b0; force_rdy = 1'b0;
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1);
    wait_vld("t6_prior_vld", 20);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (8 + 4 * BD + 4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_data", 32'(rx_bus.data_o), 32'h00);
        check("t6_rst_vld", 32'(rx_bus.data_vld_o), 32'd0);
        check("t6_rst_ferr", 32'(rx_bus.frame_err_o), 32'd0);
        check("t6_rst_ovr", 32'(rx_bus.overrun_o), 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
      end
    join
    auto_rdy = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_partial", 32'(rx_bus.data_vld_o), 32'd0);
    exp_q.push_back(8'h2B);
    send_byte(8'h2B, 1'b1);
    repeat (30) @(negedge clk);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Byte-oriented UART receiver that turns the serial line into the parallel byte stream consumed by the RAM read/write command controller.
- Samples the asynchronous rx pin at mid-bit and frames 8N1 characters.
- Presents each byte with a valid/ready handshake. The consumer edge-detects valid and holds ready high until valid drops.
- Flags framing errors and overruns to status/debug logic.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200). Legal range >= 4; out-of-range is an elaboration error.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- rx_i  in  1  serial input, asynchronous to clk_i, idle high
- data_o  out  8  received byte, LSB first on line
- data_vld_o  out  1  data_o holds an unconsumed byte
- data_rdy_i  in  1  consumer has taken the byte
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: byte completed while previous still valid

Behaviour:
- Reset: while rst_i is high, and asynchronously on its assertion:
  - data_o=8'h00, data_vld_o=0, frame_err_o=0, overrun_o=0.
  - State=IDLE, counters cleared, synchronizer flops set to 1.
- Synchronizer: rx_i passes through 2 flops; rx_s denotes the second flop output. All decisions use rx_s.
- Counter: width $clog2(BAUD_DIV), cleared on every state entry. A state "fires" on the cycle where cnt == N-1.
- IDLE:
  - rx_s==0 -> START.
- START (N = BAUD_DIV/2, integer division):
  - On fire, rx_s==0 -> DATA with bit index=0.
  - On fire, rx_s==1 -> IDLE (glitch rejected, no output, no error).
- DATA (N = BAUD_DIV):
  - On fire, shift rx_s into shift-register bit[idx], LSB first.
  - After idx 7 -> STOP; otherwise idx+1.
- STOP (N = BAUD_DIV), on fire:
  - rx_s==1, data_vld_o==0: data_o<=shift register, data_vld_o<=1 next edge; -> IDLE.
  - rx_s==1, data_vld_o==1: new byte discarded, data_o unchanged, overrun_o pulses 1 cycle; -> IDLE.
  - rx_s==0: byte discarded, frame_err_o pulses 1 cycle, data_vld_o unchanged; -> BREAK.
- BREAK:
  - Wait for rx_s==1, then -> IDLE. No start detection while the line is held low.
- Return to IDLE at mid-stop-bit, so a back-to-back start bit is never missed.
- Handshake:
  - data_vld_o==1 and data_rdy_i==1 sampled on an edge -> data_vld_o=0 on that edge.
  - data_o stays stable while data_vld_o==1.
  - data_rdy_i while data_vld_o==0 is ignored.
  - Consumer holding data_rdy_i high across cycles is legal. A new byte may still assert data_vld_o while data_rdy_i is high; the consumer's edge detection handles the re-rise.
- Simultaneous events: STOP fire with data_vld_o==1 and data_rdy_i==1 in the same cycle:
  - Old byte is consumed; new byte is loaded; data_vld_o stays 1; no overrun.
- Latency: data_vld_o rises 3 + BAUD_DIV/2 + 9*BAUD_DIV cycles after the rx_i falling edge, +/-1 for synchronizer phase.
- frame_err_o and overrun_o are never asserted in the same cycle and are never held beyond one cycle.
- Reset mid-frame: the partial byte is lost. After release the block waits in IDLE for the next falling edge; a line already low at release is treated as a start bit.

Test Plan:
- BAUD_DIV=8, send 0xA5 (8N1), data_rdy_i held 0 -> data_vld_o=1 at 3+4+72 cycles +/-1 with data_o=0xA5, held for 50 cycles. Then data_rdy_i=1 -> data_vld_o=0 next edge.
- Back-to-back 0x2E, 0x55 with no idle gap, consumer asserting ready 2 cycles after each valid -> two bytes delivered in order, no overrun_o, no frame_err_o.
- Send 0x11 unconsumed, then 0x22 -> overrun_o single pulse at the second stop sample; data_o still 0x11. After ready, data_vld_o=0 and no further byte appears.
- Send 0x3C with stop bit forced 0, line held low 30 bits, then high, then 0x7E -> one frame_err_o pulse, no valid for 0x3C, no spurious starts during the low period, 0x7E delivered.
- Glitch: rx_i low for 2 cycles (< BAUD_DIV/2=4) -> no data_vld_o, no error pulses, block back in IDLE; a following 0x2A is received correctly.
- Assert rst_i during bit 4 of 0xF0 with data_vld_o=1 from a prior byte -> all outputs 0 immediately. After release, a fresh 0x2B is received with data_o=0x2B.
